// File: rtl/add_arbiter_if.sv
// Bundle between the three adder requesters and add_arbiter.
// The requester side owns req and the operands; the arbiter owns the rest.
interface add_arbiter_if #(parameter int N = 5) ();
  logic [2:0]   req;
  logic [N-1:0] a0;
  logic [N-1:0] b0;
  logic [N-1:0] a1;
  logic [N-1:0] b1;
  logic [N-1:0] a2;
  logic [N-1:0] b2;
  logic [2:0]   gnt;
  logic [2:0]   done;
  logic [N-1:0] result;
  logic         carry;
  logic         busy;

  modport master (
    output req, a0, b0, a1, b1, a2, b2,
    input  gnt, done, result, carry, busy
  );

  modport slave (
    input  req, a0, b0, a1, b1, a2, b2,
    output gnt, done, result, carry, busy
  );
endinterface

// File: rtl/add_arbiter.sv
// Round-robin sequencer sharing one add2 adder among PC-increment, branch-target
// and effective-address requesters; one registered add in flight at a time.
module add2 #(parameter int N = 5) (
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  output logic [N-1:0] sum_o,
  output logic         carry_o
);
  assign {carry_o, sum_o} = {1'b0, a_i} + {1'b0, b_i};
endmodule

module add_arbiter #(parameter int N = 5) (
  input  logic         clk,
  input  logic         rst_n,
  add_arbiter_if.slave bus
);
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_EXEC = 2'd1, S_DONE = 2'd2} state_t;

  state_t       state_q, state_d;
  logic [1:0]   ptr_q, ptr_d;
  logic [1:0]   owner_q, owner_d;
  logic [1:0]   win_s;
  logic [N-1:0] opa_q, opa_d, opb_q, opb_d;
  logic [N-1:0] result_q, result_d, sum_s;
  logic [2:0]   gnt_q, gnt_d, done_q, done_d;
  logic         carry_q, carry_d, cout_s;
  logic         busy_q, busy_d;

  add2 #(.N(N)) u_add2 (.a_i(opa_q), .b_i(opb_q), .sum_o(sum_s), .carry_o(cout_s));

  // Winner is the first set request at or above ptr, wrapping modulo 3.
  always_comb begin
    win_s = 2'd0;
    case (ptr_q)
      2'd1: begin
        if (bus.req[1])      win_s = 2'd1;
        else if (bus.req[2]) win_s = 2'd2;
        else                 win_s = 2'd0;
      end
      2'd2: begin
        if (bus.req[2])      win_s = 2'd2;
        else if (bus.req[0]) win_s = 2'd0;
        else                 win_s = 2'd1;
      end
      default: begin
        if (bus.req[0])      win_s = 2'd0;
        else if (bus.req[1]) win_s = 2'd1;
        else                 win_s = 2'd2;
      end
    endcase
  end

  // Next state; gnt and done default low so each is a single-cycle pulse.
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    owner_d  = owner_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    result_d = result_q;
    carry_d  = carry_q;
    gnt_d    = 3'b000;
    done_d   = 3'b000;
    case (state_q)
      S_IDLE: begin
        if (bus.req != 3'b000) begin
          owner_d = win_s;
          gnt_d   = 3'b001 << win_s;
          state_d = S_EXEC;
          case (win_s)
            2'd1:    begin opa_d = bus.a1; opb_d = bus.b1; end
            2'd2:    begin opa_d = bus.a2; opb_d = bus.b2; end
            default: begin opa_d = bus.a0; opb_d = bus.b0; end
          endcase
        end else begin
          state_d = S_IDLE;
        end
      end
      S_EXEC: begin
        result_d = sum_s;
        carry_d  = cout_s;
        done_d   = 3'b001 << owner_q;
        state_d  = S_DONE;
      end
      S_DONE: begin
        ptr_d   = (owner_q == 2'd2) ? 2'd0 : owner_q + 2'd1;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // State and output registers; reset discards any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      ptr_q    <= 2'd0;
      owner_q  <= 2'd0;
      opa_q    <= {N{1'b0}};
      opb_q    <= {N{1'b0}};
      result_q <= {N{1'b0}};
      carry_q  <= 1'b0;
      gnt_q    <= 3'b000;
      done_q   <= 3'b000;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      owner_q  <= owner_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      result_q <= result_d;
      carry_q  <= carry_d;
      gnt_q    <= gnt_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
    end
  end

  assign bus.gnt    = gnt_q;
  assign bus.done   = done_q;
  assign bus.result = result_q;
  assign bus.carry  = carry_q;
  assign bus.busy   = busy_q;
endmodule
